// File: rtl/comp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
package comp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } comp_state_e;

    // Result vector is ordered {Less, Equal, Greater}
    localparam logic [2:0] RES_NONE    = 3'b000;
    localparam logic [2:0] RES_LESS    = 3'b100;
    localparam logic [2:0] RES_EQUAL   = 3'b010;
    localparam logic [2:0] RES_GREATER = 3'b001;

    function automatic int su_width(input int nslice);
        return $clog2(nslice + 1);
    endfunction

    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/comp_slice.sv
// One DIGIT-bit comparator slice with chained equality input.
module comp_slice #(
    parameter int DIGIT = 2
) (
    input  logic             Equ_In,
    input  logic [DIGIT-1:0] A_s,
    input  logic [DIGIT-1:0] B_s,
    output logic             Less_S,
    output logic             Equal_S
);

    assign Less_S  = Equ_In && (A_s < B_s);
    assign Equal_S = Equ_In && (A_s == B_s);

endmodule

// File: rtl/comp_seq_n.sv
// Sequential MSB-first magnitude comparator, DIGIT bits per cycle, early exit.
// Optional two's-complement mode when COMP_SIGNED_EN is defined.
module comp_seq_n
    import comp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic                                 Clk,
    input  logic                                 Reset_n,
    input  logic                                 In_Valid,
    output logic                                 In_Ready,
    input  logic [WIDTH-1:0]                     A,
    input  logic [WIDTH-1:0]                     B,
`ifdef COMP_SIGNED_EN
    input  logic                                 Signed_Mode,
`endif
    output logic                                 Out_Valid,
    input  logic                                 Out_Ready,
    output logic                                 Less,
    output logic                                 Equal,
    output logic                                 Greater,
    output logic [su_width(WIDTH/DIGIT)-1:0]     Slices_Used
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int SUW    = su_width(NSLICE);
    localparam int IDXW   = idx_width(NSLICE);

    comp_state_e      state, state_n;
    logic [WIDTH-1:0] a_r, b_r;
    logic [IDXW-1:0]  idx;
    logic [SUW-1:0]   used;
    logic [2:0]       res;
    logic [WIDTH-1:0] flip;
    logic [DIGIT-1:0] a_s, b_s;
    logic             lt_s, eq_s;

    // Flipping the sign bit of both operands maps two's complement onto unsigned order
    always_comb begin
        flip = '0;
`ifdef COMP_SIGNED_EN
        flip[WIDTH-1] = Signed_Mode;
`endif
    end

    always_comb begin
        a_s = '0;
        b_s = '0;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            if (idx == IDXW'(i)) begin
                a_s = a_r[i*DIGIT +: DIGIT];
                b_s = b_r[i*DIGIT +: DIGIT];
            end
        end
    end

    comp_slice #(
        .DIGIT(DIGIT)
    ) u_slice (
        .Equ_In  (1'b1),
        .A_s     (a_s),
        .B_s     (b_s),
        .Less_S  (lt_s),
        .Equal_S (eq_s)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        In_Ready  = 1'b0;
        Out_Valid = 1'b0;
        case (state)
            IDLE: begin
                In_Ready = 1'b1;
                if (In_Valid) state_n = RUN;
            end
            RUN: begin
                if (!eq_s || idx == '0) state_n = DONE;
            end
            DONE: begin
                Out_Valid = 1'b1;
                if (Out_Ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_r  <= '0;
            b_r  <= '0;
            idx  <= '0;
            used <= '0;
            res  <= RES_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (In_Valid) begin
                        a_r  <= A ^ flip;
                        b_r  <= B ^ flip;
                        idx  <= IDXW'(NSLICE - 1);
                        used <= '0;
                    end
                end
                RUN: begin
                    used <= used + SUW'(1);
                    if (lt_s) begin
                        res <= RES_LESS;
                    end else if (!eq_s) begin
                        res <= RES_GREATER;
                    end else if (idx == '0) begin
                        res <= RES_EQUAL;
                    end else begin
                        idx <= idx - IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign Less        = res[2];
    assign Equal       = res[1];
    assign Greater     = res[0];
    assign Slices_Used = used;

endmodule

// File: tb/tb_comp_seq_n.sv
// Randomised and directed bench for comp_seq_n against a behavioural model.
module tb_comp_seq_n;

    localparam int W   = 8;
    localparam int D   = 2;
    localparam int NS  = W / D;
    localparam int SUW = $clog2(NS + 1);

    logic           Clk = 1'b0;
    logic           Reset_n, In_Valid, In_Ready, Out_Valid, Out_Ready;
    logic           Less, Equal, Greater;
    logic [W-1:0]   A, B;
    logic [SUW-1:0] Slices_Used;
`ifdef COMP_SIGNED_EN
    logic           Signed_Mode;
    logic           sm16;
`endif

    logic        iv16, ir16, ov16, lt16, eq16, gt16;
    logic [15:0] a16, b16;
    logic [2:0]  su16;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   exp_k = 0;
    logic [2:0] exp_res = 3'b000;
    bit   busy = 0;
    bit   chk_en = 0;
    bit   prev_ov = 0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    comp_seq_n #(
        .WIDTH(W),
        .DIGIT(D)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .In_Valid    (In_Valid),
        .In_Ready    (In_Ready),
        .A           (A),
        .B           (B),
`ifdef COMP_SIGNED_EN
        .Signed_Mode (Signed_Mode),
`endif
        .Out_Valid   (Out_Valid),
        .Out_Ready   (Out_Ready),
        .Less        (Less),
        .Equal       (Equal),
        .Greater     (Greater),
        .Slices_Used (Slices_Used)
    );

    comp_seq_n #(
        .WIDTH(16),
        .DIGIT(4)
    ) dut16 (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .In_Valid    (iv16),
        .In_Ready    (ir16),
        .A           (a16),
        .B           (b16),
`ifdef COMP_SIGNED_EN
        .Signed_Mode (sm16),
`endif
        .Out_Valid   (ov16),
        .Out_Ready   (1'b1),
        .Less        (lt16),
        .Equal       (eq16),
        .Greater     (gt16),
        .Slices_Used (su16)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // {Less, Equal, Greater} straight from the numeric relation
    function automatic logic [2:0] mdl_res(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm);
        if (sm) return {$signed(a) < $signed(b), a == b, $signed(a) > $signed(b)};
        return {a < b, a == b, a > b};
    endfunction

    // Slices consumed: first k where the top k*D bits differ, else all of them
    function automatic int mdl_k(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int k = 1; k <= NS; k++) begin
            if ((a >> (W - k*D)) != (b >> (W - k*D))) return k;
        end
        return NS;
    endfunction

    always @(negedge Clk) begin
        if (Reset_n && chk_en) begin
            chk("in_ready", {31'd0, In_Ready}, {31'd0, !busy});
            if (!busy) chk("out_valid_idle", {31'd0, Out_Valid}, 32'd0);
            if (busy && Out_Valid) begin
                chk("flags", {29'd0, Less, Equal, Greater}, {29'd0, exp_res});
                chk("slices_used", {29'd0, Slices_Used}, exp_k);
                if (!prev_ov) chk("latency", cyc - acc_cyc, exp_k);
            end
            prev_ov = Out_Valid;
        end else begin
            prev_ov = 0;
        end
    end

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm,
                      input logic [2:0] er, input int ek, input int hold);
        int n;
        @(negedge Clk);
        A = a;
        B = b;
`ifdef COMP_SIGNED_EN
        Signed_Mode = sm;
`endif
        In_Valid = 1'b1;
        @(posedge Clk);
        #1;
        acc_cyc = cyc;
        exp_res = er;
        exp_k   = ek;
        busy    = 1;
        In_Valid = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
`ifdef COMP_SIGNED_EN
        Signed_Mode = ~sm;
`endif
        n = 0;
        @(negedge Clk);
        while (!Out_Valid && n < 40) begin
            In_Valid  = 1'($urandom_range(0, 1));
            Out_Ready = 1'($urandom_range(0, 1));
            @(negedge Clk);
            n++;
        end
        if (!Out_Valid) chk("timeout", 32'd0, 32'd1);
        Out_Ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            In_Valid = 1'($urandom_range(0, 1));
            @(negedge Clk);
        end
        In_Valid  = 1'b0;
        Out_Ready = 1'b1;
        @(posedge Clk);
        #1;
        busy = 0;
        Out_Ready = 1'b0;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_in_ready"}, {31'd0, In_Ready}, 32'd1);
        chk({nm, "_out_valid"}, {31'd0, Out_Valid}, 32'd0);
        chk({nm, "_flags"}, {29'd0, Less, Equal, Greater}, 32'd0);
        chk({nm, "_slices_used"}, {29'd0, Slices_Used}, 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        bit rsm;
        int n;
        Reset_n = 1'b0;
        In_Valid = 1'b0;
        Out_Ready = 1'b0;
        A = '0;
        B = '0;
`ifdef COMP_SIGNED_EN
        Signed_Mode = 1'b0;
        sm16 = 1'b0;
`endif
        iv16 = 1'b0;
        a16 = '0;
        b16 = '0;
        #12;
        chk_reset_vals("por");
        @(negedge Clk);
        Reset_n = 1'b1;
        chk_en = 1;

        // pin the model on hand-computed cases
        chk("mdl_35_80", {29'd0, mdl_res(8'h35, 8'h80, 0)}, 32'b100);
        chk("mdl_k_35_80", mdl_k(8'h35, 8'h80), 1);
        chk("mdl_k_a5_a5", mdl_k(8'hA5, 8'hA5), 4);
        chk("mdl_k_3f_2f", mdl_k(8'h3F, 8'h2F), 2);
        chk("mdl_signed_80_01", {29'd0, mdl_res(8'h80, 8'h01, 1)}, 32'b100);

        op(8'h35, 8'h80, 0, 3'b100, 1, 0);
        op(8'hA5, 8'hA5, 0, 3'b010, 4, 0);
        op(8'hA6, 8'hA5, 0, 3'b001, 4, 1);
        op(8'h3F, 8'h2F, 0, 3'b001, 2, 0);
        op(8'h12, 8'h34, 0, 3'b100, 2, 3);

        // abort mid-RUN
        @(negedge Clk);
        A = 8'hFF;
        B = 8'hFF;
`ifdef COMP_SIGNED_EN
        Signed_Mode = 1'b0;
`endif
        In_Valid = 1'b1;
        @(posedge Clk);
        #1;
        acc_cyc = cyc;
        exp_res = 3'b010;
        exp_k = 4;
        busy = 1;
        In_Valid = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("pre_abort_slices", {29'd0, Slices_Used}, 32'd2);
        Reset_n = 1'b0;
        #1;
        busy = 0;
        chk_reset_vals("abort");
        @(negedge Clk);
        Reset_n = 1'b1;
        op(8'h01, 8'h02, 0, 3'b100, 4, 0);

`ifdef COMP_SIGNED_EN
        op(8'h80, 8'h01, 1, 3'b100, 1, 0);
        op(8'h80, 8'h01, 0, 3'b001, 1, 0);
`endif

        for (int t = 0; t < 60; t++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ W'(1 << $urandom_range(0, W - 1));
                default: rb = W'($urandom);
            endcase
            rsm = 0;
`ifdef COMP_SIGNED_EN
            rsm = 1'($urandom_range(0, 1));
`endif
            op(ra, rb, rsm, mdl_res(ra, rb, rsm), mdl_k(ra, rb), $urandom_range(0, 3));
        end

        // wider configuration
        @(negedge Clk);
        a16 = 16'h1234;
        b16 = 16'h1235;
        iv16 = 1'b1;
        @(posedge Clk);
        #1;
        acc_cyc = cyc;
        iv16 = 1'b0;
        n = 0;
        @(negedge Clk);
        while (!ov16 && n < 40) begin
            @(negedge Clk);
            n++;
        end
        chk("w16_latency", cyc - acc_cyc, 4);
        chk("w16_flags", {29'd0, lt16, eq16, gt16}, 32'b100);
        chk("w16_slices_used", {29'd0, su16}, 32'd4);
        chk("w16_in_ready_busy", {31'd0, ir16}, 32'd0);

        repeat (3) @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
